// File: rtl/uart_tx_scheduler_if.sv
// Store-side and uart-side signals of the UART transmit scheduler.
// The master drives stores (the pipeline); the slave is the scheduler.
interface uart_tx_scheduler_if #(
  parameter int DEPTH = 16
);
  logic                   st_valid;
  logic [7:0]             st_data;
  logic                   st_stall;
  logic                   uart_wr;
  logic [7:0]             uart_dat;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   tx_idle;

  modport master (
    output st_valid, st_data,
    input  st_stall, uart_wr, uart_dat, fifo_count, tx_idle
  );

  modport slave (
    input  st_valid, st_data,
    output st_stall, uart_wr, uart_dat, fifo_count, tx_idle
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: buffers stored bytes in a FIFO and hands them to
// the uart one frame at a time. The uart has no busy flag, so each frame is
// timed here with a down-counter loaded on every write pulse.
module uart_tx_scheduler #(
  parameter int DEPTH           = 16,
  parameter int CYCLES_PER_BYTE = 10850
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CYCLES_PER_BYTE);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [CW-1:0] WAIT_LD  = CW'(CYCLES_PER_BYTE - 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t        state, next_state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [CW-1:0] cnt;
  logic          uart_wr_q;
  logic [7:0]    uart_dat_q;
  logic          full, push, pop;

  // Full is judged on the pre-pop count, so a full FIFO stalls even while
  // the same cycle pops.
  assign full = (count == FULL_CNT);
  assign push = bus.st_valid && !full;

  assign bus.st_stall   = bus.st_valid && full;
  assign bus.uart_wr    = uart_wr_q;
  assign bus.uart_dat   = uart_dat_q;
  assign bus.fifo_count = count;
  assign bus.tx_idle    = (state == IDLE) && (count == '0);

  // Next-state logic; SEND lasts exactly one cycle and pops the head.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (count != '0) next_state = SEND;
      SEND: begin
        pop        = 1'b1;
        next_state = WAIT;
      end
      WAIT: if (cnt == '0) next_state = (count != '0) ? SEND : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FIFO storage; contents need no reset since the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wptr] <= bus.st_data;
  end

  // Pointers, occupancy, frame timer and the registered uart drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      cnt        <= '0;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= 8'h00;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Loaded with CYCLES_PER_BYTE-2: one cycle is spent in SEND and one
      // more on the WAIT->SEND edge, giving exact frame spacing.
      if (state == SEND)                  cnt <= WAIT_LD;
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      // Pulse is high exactly while the FSM sits in SEND.
      uart_wr_q <= (next_state == SEND);
      if (next_state == SEND) uart_dat_q <= mem[rptr];
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler with DEPTH=4, CYCLES_PER_BYTE=8.
module tb_uart_tx_scheduler;
  localparam int DEPTH = 4;
  localparam int CPB   = 8;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   saw_stall = 1'b0;

  uart_tx_scheduler_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_scheduler #(.DEPTH(DEPTH), .CYCLES_PER_BYTE(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pulse monitor: byte and cycle of every uart write pulse.
  logic [7:0] pq_dat[$];
  int         pq_cyc[$];
  always @(negedge clk) begin
    if (bus.uart_wr === 1'b1) begin
      pq_dat.push_back(bus.uart_dat);
      pq_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       wr;
    logic [7:0] dat;
    logic [2:0] cnt;
    logic       idle;
    logic       stall;
  } vec_t;

  vec_t tv[37];

  function automatic vec_t mk(logic v, logic [7:0] d, logic wr, logic [7:0] dat,
                              logic [2:0] cnt, logic idle);
    vec_t r;
    r.v = v; r.d = d; r.wr = wr; r.dat = dat; r.cnt = cnt; r.idle = idle;
    r.stall = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present a byte and hold it until accepted; pcyc is the cycle it was sampled in.
  task automatic push_byte(input logic [7:0] d, output int pcyc);
    int w;
    w = 0;
    @(negedge clk);
    bus.st_valid = 1'b1;
    bus.st_data  = d;
    #1;
    while (bus.st_stall && w < 100) begin
      if (!saw_stall) begin
        saw_stall = 1'b1;
        chk("stall_at_full_count", 32'(bus.fifo_count), 32'd4);
      end
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 100) chk("push_timeout", 32'd1, 32'd0);
    pcyc = cyc;
    @(posedge clk);
    #1;
    bus.st_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.tx_idle && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_q();
    pq_dat.delete();
    pq_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int w;
    logic [7:0] sent[$];

    // ---- vector table: single byte then a 3-byte burst ----
    tv[0] = mk(1, 8'h41, 0, 8'h00, 1, 0);
    tv[1] = mk(0, 8'h00, 1, 8'h41, 1, 0);
    for (int i = 2; i <= 8; i++) tv[i] = mk(0, 8'h00, 0, 8'h41, 0, 0);
    tv[9]  = mk(0, 8'h00, 0, 8'h41, 0, 1);
    tv[10] = mk(0, 8'h00, 0, 8'h41, 0, 1);
    tv[11] = mk(1, 8'h48, 0, 8'h41, 1, 0);
    tv[12] = mk(1, 8'h69, 1, 8'h48, 2, 0);
    tv[13] = mk(1, 8'h21, 0, 8'h48, 2, 0);
    for (int i = 14; i <= 19; i++) tv[i] = mk(0, 8'h00, 0, 8'h48, 2, 0);
    tv[20] = mk(0, 8'h00, 1, 8'h69, 2, 0);
    for (int i = 21; i <= 27; i++) tv[i] = mk(0, 8'h00, 0, 8'h69, 1, 0);
    tv[28] = mk(0, 8'h00, 1, 8'h21, 1, 0);
    for (int i = 29; i <= 35; i++) tv[i] = mk(0, 8'h00, 0, 8'h21, 0, 0);
    tv[36] = mk(0, 8'h00, 0, 8'h21, 0, 1);

    // ---- reset, with st_valid asserted: reset must win ----
    reset = 1'b1;
    bus.st_valid = 1'b1;
    bus.st_data  = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uart_wr", 32'(bus.uart_wr), 32'd0);
    chk("rst_uart_dat", 32'(bus.uart_dat), 32'h00);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_tx_idle", 32'(bus.tx_idle), 32'd1);
    chk("rst_stall", 32'(bus.st_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.st_valid = 1'b0;

    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      bus.st_valid = tv[i].v;
      bus.st_data  = tv[i].d;
      #1;
      chk($sformatf("row%0d_stall", i), 32'(bus.st_stall), 32'(tv[i].stall));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_wr", i), 32'(bus.uart_wr), 32'(tv[i].wr));
      chk($sformatf("row%0d_dat", i), 32'(bus.uart_dat), 32'(tv[i].dat));
      chk($sformatf("row%0d_count", i), 32'(bus.fifo_count), 32'(tv[i].cnt));
      chk($sformatf("row%0d_idle", i), 32'(bus.tx_idle), 32'(tv[i].idle));
    end
    bus.st_valid = 1'b0;

    // ---- full/stall: 6 bytes, held while stalled ----
    clear_q();
    for (int k = 0; k < 6; k++) push_byte(8'(k), p);
    chk("full_saw_stall", 32'(saw_stall), 32'd1);
    wait_idle();
    chk("full_n_pulses", 32'(pq_dat.size()), 32'd6);
    for (int k = 0; k < 6 && k < pq_dat.size(); k++) begin
      chk($sformatf("full_byte%0d", k), 32'(pq_dat[k]), 32'(k));
      if (k > 0) chk($sformatf("full_gap%0d", k), 32'(pq_cyc[k] - pq_cyc[k-1]), 32'd8);
    end

    // ---- push during SEND with FIFO full ----
    clear_q();
    for (int k = 0; k < 5; k++) push_byte(8'hA0 + 8'(k), p);
    w = 0;
    @(negedge clk);
    while (!(bus.uart_wr && bus.fifo_count == 3'd4) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("pp_reach_full_send", 32'(w < 50), 32'd1);
    bus.st_valid = 1'b1;
    bus.st_data  = 8'hA5;
    #1;
    chk("pp_stall_in_send", 32'(bus.st_stall), 32'd1);
    @(posedge clk);
    #1;
    chk("pp_count_after_pop", 32'(bus.fifo_count), 32'd3);
    chk("pp_stall_released", 32'(bus.st_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("pp_count_refill", 32'(bus.fifo_count), 32'd4);
    bus.st_valid = 1'b0;
    wait_idle();
    chk("pp_n_pulses", 32'(pq_dat.size()), 32'd6);
    for (int k = 0; k < 6 && k < pq_dat.size(); k++)
      chk($sformatf("pp_byte%0d", k), 32'(pq_dat[k]), 32'(8'hA0 + 8'(k)));

    // ---- pointer wrap: 20 bytes with random gaps ----
    clear_q();
    for (int k = 0; k < 20; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      sent.push_back(b);
      push_byte(b, p);
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    wait_idle();
    chk("wrap_n_pulses", 32'(pq_dat.size()), 32'd20);
    for (int k = 0; k < 20 && k < pq_dat.size(); k++) begin
      chk($sformatf("wrap_byte%0d", k), 32'(pq_dat[k]), 32'(sent[k]));
      if (k > 0) chk($sformatf("wrap_gap_ok%0d", k), 32'((pq_cyc[k] - pq_cyc[k-1]) >= 8), 32'd1);
    end

    // ---- reset mid-burst ----
    for (int k = 0; k < 4; k++) push_byte(8'hC0 + 8'(k), p);
    chk("mid_pre_count", 32'(bus.fifo_count), 32'd3);
    chk("mid_pre_wr", 32'(bus.uart_wr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.st_valid = 1'b1;
    bus.st_data  = 8'hFF;
    @(posedge clk);
    #1;
    chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("mid_rst_idle", 32'(bus.tx_idle), 32'd1);
    chk("mid_rst_wr", 32'(bus.uart_wr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.st_valid = 1'b0;
    clear_q();
    repeat (20) @(negedge clk);
    chk("mid_no_pulses", 32'(pq_dat.size()), 32'd0);
    push_byte(8'h5A, p);
    wait_idle();
    chk("mid_new_n", 32'(pq_dat.size()), 32'd1);
    if (pq_dat.size() > 0) begin
      chk("mid_new_dat", 32'(pq_dat[0]), 32'h5A);
      chk("mid_new_latency", 32'(pq_cyc[0] - p), 32'd2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
